// File: rtl/decred_result_collector.sv
// Round-robin collector of winning nonces from the hash macros.
// Each flagged macro is read once (4 nonce bytes) and queued as {id, nonce}.
module decred_result_collector #(
    parameter int         NUM_MACROS = 4,
    parameter logic [5:0] NONCE_ADDR = 6'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          CLEAR,
    input  logic [NUM_MACROS-1:0]         DATA_AVAILABLE,
    output logic [NUM_MACROS-1:0]         MACRO_RD_SELECT,
    output logic [5:0]                    HASH_ADDR,
    input  logic [7:0]                    DATA_FROM_HASH,
    input  logic                          RESULT_POP,
    output logic                          RESULT_VALID,
    output logic [39:0]                   RESULT_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          IRQ_OUT
);
    localparam int IW = $clog2(NUM_MACROS);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DRAIN, PUSH} state_t;

    state_t                 state_reg, state_next;
    logic [IW-1:0]          g_reg, g_next;
    logic [IW-1:0]          rr_reg, rr_next;
    logic [1:0]             k_reg, k_next;
    logic [31:0]            nonce_reg, nonce_next;
    logic [NUM_MACROS-1:0]  served_reg, served_next;
    logic [NUM_MACROS-1:0]  eligible;
    logic                   found;
    logic [IW-1:0]          pick;

    logic [39:0]            fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]            level_reg;
    logic                   irq_reg;
    logic                   fifo_full, fifo_empty, do_push, do_pop;

    assign fifo_full  = (level_reg == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (level_reg == '0);
    assign do_push    = (state_reg == PUSH) && !fifo_full && !CLEAR;
    assign do_pop     = RESULT_POP && !fifo_empty && !CLEAR;

    // The push marks the macro served even if its flag already dropped;
    // a low flag then clears it on the following edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MACROS; gi++) begin : g_macro
            assign eligible[gi]        = DATA_AVAILABLE[gi] & ~served_reg[gi];
            assign served_next[gi]     = !CLEAR &&
                                         ((do_push && (g_reg == IW'(gi))) ||
                                          (DATA_AVAILABLE[gi] && served_reg[gi]));
            assign MACRO_RD_SELECT[gi] = (state_reg == ADDR) && (g_reg == IW'(gi));
        end
    endgenerate

    assign HASH_ADDR = (state_reg == ADDR) ? (NONCE_ADDR + {4'b0000, k_reg}) : 6'd0;

    // Scan upward from the round-robin pointer with wrap.
    always_comb begin
        logic [IW:0] sum;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int j = 0; j < NUM_MACROS; j++) begin
            sum = {1'b0, rr_reg} + (IW+1)'(j);
            if (sum >= (IW+1)'(NUM_MACROS))
                sum = sum - (IW+1)'(NUM_MACROS);
            if (!found && eligible[sum[IW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        k_next     = k_reg;
        nonce_next = nonce_reg;
        rr_next    = rr_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    g_next     = pick;
                    k_next     = 2'd0;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                // Read data lags the address by one cycle.
                case (k_reg)
                    2'd1:    nonce_next[7:0]   = DATA_FROM_HASH;
                    2'd2:    nonce_next[15:8]  = DATA_FROM_HASH;
                    2'd3:    nonce_next[23:16] = DATA_FROM_HASH;
                    default: ;
                endcase
                k_next = k_reg + 2'd1;
                if (k_reg == 2'd3)
                    state_next = DRAIN;
            end
            DRAIN: begin
                nonce_next[31:24] = DATA_FROM_HASH;
                state_next        = PUSH;
            end
            PUSH: begin
                if (!fifo_full) begin
                    rr_next    = (g_reg == IW'(NUM_MACROS-1)) ? '0 : g_reg + IW'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (CLEAR) begin
            state_next = IDLE;
            k_next     = 2'd0;
            rr_next    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= IDLE;
            g_reg      <= '0;
            rr_reg     <= '0;
            k_reg      <= 2'd0;
            nonce_reg  <= '0;
            served_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            irq_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            g_reg      <= g_next;
            rr_reg     <= rr_next;
            k_reg      <= k_next;
            nonce_reg  <= nonce_next;
            served_reg <= served_next;
            irq_reg    <= !fifo_empty;
            if (CLEAR) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (do_push)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (do_pop)
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                case ({do_push, do_pop})
                    2'b10:   level_reg <= level_reg + (PW+1)'(1);
                    2'b01:   level_reg <= level_reg - (PW+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push)
            fifo_mem[wr_ptr_reg] <= {{(8-IW){1'b0}}, g_reg, nonce_reg};
    end

    assign RESULT_VALID = !fifo_empty;
    assign RESULT_DATA  = fifo_empty ? 40'd0 : fifo_mem[rd_ptr_reg];
    assign FIFO_LEVEL   = level_reg;
    assign IRQ_OUT      = irq_reg;

endmodule

// File: tb/tb_decred_result_collector.sv
// Scoreboard bench for decred_result_collector: expected entries are queued at
// stimulus time and compared by a monitor whenever an entry is popped.
module tb_decred_result_collector;
    localparam int         N    = 5;
    localparam int         D    = 4;
    localparam logic [5:0] BASE = 6'h10;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b1;
    logic         CLEAR = 1'b0;
    logic [N-1:0] DATA_AVAILABLE = '0;
    logic [N-1:0] MACRO_RD_SELECT;
    logic [5:0]   HASH_ADDR;
    logic [7:0]   DATA_FROM_HASH = 8'h00;
    logic         RESULT_POP = 1'b0;
    logic         RESULT_VALID;
    logic [39:0]  RESULT_DATA;
    logic [2:0]   FIFO_LEVEL;
    logic         IRQ_OUT;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];
    logic [31:0] nonce_tab [N] = '{32'h44332211, 32'hD4C3B2A1, 32'h04030201,
                                   32'hEFBEADDE, 32'h88776655};

    decred_result_collector #(.NUM_MACROS(N), .NONCE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
        .DATA_AVAILABLE(DATA_AVAILABLE), .MACRO_RD_SELECT(MACRO_RD_SELECT),
        .HASH_ADDR(HASH_ADDR), .DATA_FROM_HASH(DATA_FROM_HASH),
        .RESULT_POP(RESULT_POP), .RESULT_VALID(RESULT_VALID),
        .RESULT_DATA(RESULT_DATA), .FIFO_LEVEL(FIFO_LEVEL), .IRQ_OUT(IRQ_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Hash-macro read port: byte returned one cycle after select/address.
    always @(posedge CLK) begin : macro_model
        logic [5:0] off;
        off = HASH_ADDR - BASE;
        DATA_FROM_HASH <= 8'h00;
        for (int i = 0; i < N; i++)
            if (MACRO_RD_SELECT[i])
                DATA_FROM_HASH <= nonce_tab[i][8*off[1:0] +: 8];
    end

    // Inputs change only at posedge+2, so values seen here apply to the next edge.
    always @(negedge CLK) begin
        if (RESET_N && !CLEAR && RESULT_POP && RESULT_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none", RESULT_DATA);
            end else begin
                chk("pop_entry", RESULT_DATA, exp_q.pop_front());
            end
        end
        if (RESET_N && MACRO_RD_SELECT != '0) begin
            chk("bus_onehot", $countones(MACRO_RD_SELECT), 1);
            chk("bus_addr_window", (HASH_ADDR >= BASE) && (HASH_ADDR <= BASE + 6'd3), 1);
        end
    end

    task automatic drv();
        @(posedge CLK);
        #2;
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 RESET_N = 1'b0;
        #2;
        chk("rst_sel", MACRO_RD_SELECT, 0);
        chk("rst_addr", HASH_ADDR, 0);
        chk("rst_valid", RESULT_VALID, 0);
        chk("rst_data", RESULT_DATA, 0);
        chk("rst_level", FIFO_LEVEL, 0);
        chk("rst_irq", IRQ_OUT, 0);
        drv();
        RESET_N = 1'b1;

        // Single macro, cycle-accurate timing from E0
        drv();
        DATA_AVAILABLE = 5'b00001;
        exp_q.push_back(40'h00_44332211);
        ncyc(1);
        for (int c = 1; c <= 4; c++) begin
            ncyc(1);
            chk("t1_sel", MACRO_RD_SELECT, 5'b00001);
            chk("t1_addr", HASH_ADDR, BASE + 6'(c - 1));
        end
        ncyc(1);
        chk("t1_drain_sel", MACRO_RD_SELECT, 0);
        chk("t1_drain_addr", HASH_ADDR, 0);
        ncyc(1);
        chk("t1_push_valid", RESULT_VALID, 0);
        ncyc(1);
        chk("t1_c7_valid", RESULT_VALID, 1);
        chk("t1_c7_data", RESULT_DATA, 40'h00_44332211);
        chk("t1_c7_level", FIFO_LEVEL, 1);
        chk("t1_c7_irq", IRQ_OUT, 0);
        ncyc(1);
        chk("t1_c8_irq", IRQ_OUT, 1);
        drv();
        RESULT_POP = 1'b1;
        drv();
        RESULT_POP = 1'b0;
        ncyc(1);
        chk("t1_level_after_pop", FIFO_LEVEL, 0);
        chk("t1_valid_after_pop", RESULT_VALID, 0);
        ncyc(10);
        chk("t1_no_reread", FIFO_LEVEL, 0);

        // Four macros held high: served once each in order, then re-arm macro 2
        drv();
        CLEAR = 1'b1;
        DATA_AVAILABLE = '0;
        drv();
        CLEAR = 1'b0;
        DATA_AVAILABLE = 5'b01111;
        RESULT_POP = 1'b1;
        exp_q.push_back(40'h00_44332211);
        exp_q.push_back(40'h01_D4C3B2A1);
        exp_q.push_back(40'h02_04030201);
        exp_q.push_back(40'h03_EFBEADDE);
        ncyc(40);
        chk("t2_level", FIFO_LEVEL, 0);
        chk("t2_all_seen", exp_q.size(), 0);
        drv();
        DATA_AVAILABLE = 5'b01011;
        drv();
        drv();
        DATA_AVAILABLE = 5'b01111;
        exp_q.push_back(40'h02_04030201);
        ncyc(15);
        chk("t2_reread_seen", exp_q.size(), 0);
        chk("t2_reread_level", FIFO_LEVEL, 0);
        drv();
        RESULT_POP = 1'b0;

        // FIFO fill with five macros, then blocked push while popping
        drv();
        CLEAR = 1'b1;
        DATA_AVAILABLE = '0;
        drv();
        CLEAR = 1'b0;
        DATA_AVAILABLE = 5'b11111;
        exp_q.push_back(40'h00_44332211);
        exp_q.push_back(40'h01_D4C3B2A1);
        exp_q.push_back(40'h02_04030201);
        exp_q.push_back(40'h03_EFBEADDE);
        exp_q.push_back(40'h04_88776655);
        ncyc(45);
        chk("t3_full_level", FIFO_LEVEL, 4);
        chk("t3_full_valid", RESULT_VALID, 1);
        chk("t3_full_irq", IRQ_OUT, 1);
        chk("t3_head", RESULT_DATA, 40'h00_44332211);
        chk("t3_no_read_sel", MACRO_RD_SELECT, 0);
        ncyc(3);
        chk("t3_hold_level", FIFO_LEVEL, 4);
        drv();
        RESULT_POP = 1'b1;
        drv();
        RESULT_POP = 1'b0;
        ncyc(1);
        chk("t3_level_after_pop", FIFO_LEVEL, 3);
        ncyc(1);
        chk("t3_level_after_push", FIFO_LEVEL, 4);
        drv();
        RESULT_POP = 1'b1;
        ncyc(10);
        chk("t3_drained_level", FIFO_LEVEL, 0);
        chk("t3_drained_valid", RESULT_VALID, 0);
        chk("t3_all_seen", exp_q.size(), 0);
        drv();
        RESULT_POP = 1'b0;

        // CLEAR during the second ADDR cycle with two entries queued
        drv();
        CLEAR = 1'b1;
        DATA_AVAILABLE = '0;
        drv();
        CLEAR = 1'b0;
        DATA_AVAILABLE = 5'b00011;
        exp_q.push_back(40'h00_44332211);
        exp_q.push_back(40'h01_D4C3B2A1);
        ncyc(20);
        chk("t4_level_two", FIFO_LEVEL, 2);
        drv();
        DATA_AVAILABLE = 5'b00111;
        ncyc(2);
        chk("t4_c1_sel", MACRO_RD_SELECT, 5'b00100);
        chk("t4_c1_addr", HASH_ADDR, BASE);
        drv();
        CLEAR = 1'b1;
        ncyc(1);
        chk("t4_c2_addr", HASH_ADDR, BASE + 6'd1);
        drv();
        CLEAR = 1'b0;
        exp_q.delete();
        exp_q.push_back(40'h00_44332211);
        exp_q.push_back(40'h01_D4C3B2A1);
        exp_q.push_back(40'h02_04030201);
        ncyc(1);
        chk("t4_clr_sel", MACRO_RD_SELECT, 0);
        chk("t4_clr_level", FIFO_LEVEL, 0);
        chk("t4_clr_valid", RESULT_VALID, 0);
        chk("t4_clr_data", RESULT_DATA, 0);
        ncyc(1);
        chk("t4_reread_sel", MACRO_RD_SELECT, 5'b00001);
        chk("t4_reread_addr", HASH_ADDR, BASE);
        drv();
        RESULT_POP = 1'b1;
        ncyc(30);
        chk("t4_all_seen", exp_q.size(), 0);
        chk("t4_level", FIFO_LEVEL, 0);
        drv();
        RESULT_POP = 1'b0;

        // Asynchronous reset in the middle of a read
        drv();
        DATA_AVAILABLE = '0;
        drv();
        DATA_AVAILABLE = 5'b01000;
        ncyc(2);
        chk("t5_sel_before", MACRO_RD_SELECT, 5'b01000);
        #2 RESET_N = 1'b0;
        #1;
        chk("t5_async_sel", MACRO_RD_SELECT, 0);
        chk("t5_async_addr", HASH_ADDR, 0);
        chk("t5_async_valid", RESULT_VALID, 0);
        chk("t5_async_level", FIFO_LEVEL, 0);
        exp_q.delete();
        exp_q.push_back(40'h03_EFBEADDE);
        drv();
        RESET_N = 1'b1;
        RESULT_POP = 1'b1;
        ncyc(15);
        chk("t5_reread_seen", exp_q.size(), 0);
        drv();
        RESULT_POP = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
